// File: rtl/regfile_writeback_ctrl_pkg.sv
// Shared types and constants for the register-file writeback controller.
package regfile_writeback_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MDU} wb_src_e;
endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer for long-latency results; dout shows the head combinationally.
// Push is ignored when full and pop is ignored when empty.
module wb_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic          doPush;
  logic          doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign dout   = mem[rdPtr];

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end
endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Sole register-file write port driver: ALU results win, buffered MDU results fill idle slots.
// One-cycle write latency; MDU side is back-pressured by mdu_ready, the ALU side only by alu_hold.
module regfile_writeback_ctrl
  import regfile_writeback_ctrl_pkg::*;
#(
  parameter int N            = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [N-1:0]          alu_data,
  input  logic                  mdu_valid,
  output logic                  mdu_ready,
  input  logic [REG_ADDR_W-1:0] mdu_rd,
  input  logic [N-1:0]          mdu_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic                  read_stall,
  output logic                  alu_hold,
  output logic                  waw_error,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] WriteRegister,
  output logic [N-1:0]          WriteData
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STARVE_LIMIT+1);

  logic [REG_ADDR_W+N-1:0] fifoHead;
  logic                    fifoFull;
  logic                    fifoEmpty;
  logic [CW-1:0]           fifoCount;
  logic                    doPush;
  logic                    selAlu;
  logic                    selMdu;
  logic [REG_ADDR_W-1:0]   headRd;
  logic [N-1:0]            headData;
  logic [NUM_REGS-1:0]     busy;
  logic [NUM_REGS-1:0]     busyNext;
  logic [SW-1:0]           starveCnt;
  logic [SW-1:0]           starveNext;
  wb_src_e                 wbSrc;

  assign mdu_ready  = (fifoCount < CW'(DEPTH));
  assign doPush     = mdu_valid & ~fifoFull;
  assign headRd     = fifoHead[REG_ADDR_W+N-1:N];
  assign headData   = fifoHead[N-1:0];
  assign read_stall = busy[rs_addr] | busy[rt_addr];

  wb_result_fifo #(.DEPTH(DEPTH), .W(REG_ADDR_W+N)) uFifo (
    .clk   (clk),
    .reset (reset),
    .push  (doPush),
    .pop   (selMdu),
    .din   ({mdu_rd, mdu_data}),
    .dout  (fifoHead),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  // During alu_hold the ALU is locked out, so the FIFO head is guaranteed a slot.
  always_comb begin
    selAlu     = alu_valid & ~alu_hold;
    selMdu     = ~selAlu & ~fifoEmpty;
    starveNext = (selAlu & ~fifoEmpty) ? starveCnt + 1'b1 : '0;
  end

  // Clear lands on the same edge the regfile captures the data; a new issue overrides it.
  always_comb begin
    busyNext = busy;
    if (RegWrite && wbSrc == WB_MDU) busyNext[WriteRegister] = 1'b0;
    if (issue_valid && issue_rd != REG_ZERO) busyNext[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite      <= 1'b0;
      WriteRegister <= REG_ZERO;
      WriteData     <= '0;
      wbSrc         <= WB_NONE;
      busy          <= '0;
      starveCnt     <= '0;
      alu_hold      <= 1'b0;
      waw_error     <= 1'b0;
    end else begin
      if (selAlu) begin
        RegWrite      <= (alu_rd != REG_ZERO);
        WriteRegister <= alu_rd;
        WriteData     <= alu_data;
        wbSrc         <= WB_ALU;
      end else if (selMdu) begin
        RegWrite      <= (headRd != REG_ZERO);
        WriteRegister <= headRd;
        WriteData     <= headData;
        wbSrc         <= WB_MDU;
      end else begin
        RegWrite <= 1'b0;
        wbSrc    <= WB_NONE;
      end

      busy <= busyNext;

      if (starveNext == SW'(STARVE_LIMIT)) begin
        alu_hold  <= 1'b1;
        starveCnt <= '0;
      end else begin
        alu_hold  <= 1'b0;
        starveCnt <= starveNext;
      end

      if (alu_valid && (alu_hold || (alu_rd != REG_ZERO && busy[alu_rd])))
        waw_error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Bench for regfile_writeback_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_regfile_writeback_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        read_stall;
  logic        alu_hold;
  logic        waw_error;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit          mRegWrite;
  logic [4:0]  mWrReg;
  logic [31:0] mWrData;
  bit          mFromMdu;
  bit   [31:0] mBusy;
  logic [36:0] mQ[$];
  int          mStarve;
  bit          mHold;
  bit          mWaw;

  regfile_writeback_ctrl #(.N(32), .DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .read_stall(read_stall),
    .alu_hold(alu_hold), .waw_error(waw_error),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData)
  );

  always #5 clk = ~clk;

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  // Advance one clock; the model applies the behavioural rules to the inputs present at that edge.
  task automatic cycle();
    int sz;
    bit aluWin;
    logic [36:0] e;
    @(posedge clk);
    if (reset) begin
      mQ.delete(); mBusy = '0; mStarve = 0; mHold = 0; mWaw = 0;
      mRegWrite = 0; mWrReg = '0; mWrData = '0; mFromMdu = 0;
    end else begin
      sz = mQ.size();
      aluWin = alu_valid && !mHold;
      if (alu_valid && (mHold || (alu_rd != 0 && mBusy[alu_rd]))) mWaw = 1;
      if (mRegWrite && mFromMdu) mBusy[mWrReg] = 0;
      if (issue_valid && issue_rd != 0) mBusy[issue_rd] = 1;
      if (aluWin) begin
        mRegWrite = (alu_rd != 0); mWrReg = alu_rd; mWrData = alu_data; mFromMdu = 0;
      end else if (sz > 0) begin
        e = mQ.pop_front();
        mRegWrite = (e[36:32] != 0); mWrReg = e[36:32]; mWrData = e[31:0]; mFromMdu = 1;
      end else begin
        mRegWrite = 0; mFromMdu = 0;
      end
      if (mdu_valid && sz < 4) mQ.push_back({mdu_rd, mdu_data});
      if (aluWin && sz > 0) mStarve++; else mStarve = 0;
      mHold = (mStarve == 8);
      if (mHold) mStarve = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1; idle(); cycle(); cycle(); reset = 0;
  endtask

  task automatic test_reset();
    rs_addr = 0; rt_addr = 0;
    reset = 1; idle(); cycle(); cycle();
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%0b exp=0", RegWrite); end
    checks++; if (WriteRegister !== 5'd0) begin failures++; $display("FAIL reset_wreg got=%0d exp=0", WriteRegister); end
    checks++; if (WriteData !== 32'd0) begin failures++; $display("FAIL reset_wdata got=%0h exp=0", WriteData); end
    checks++; if (read_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", read_stall); end
    checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", mdu_ready); end
    checks++; if (alu_hold !== 1'b0 || waw_error !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b exp=00", alu_hold, waw_error); end
    reset = 0;
  endtask

  task automatic test_alu_write();
    idle(); alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    cycle(); idle();
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 32'hDEADBEEF) begin
      failures++; $display("FAIL alu_write got=%0b/%0d/%0h exp=1/5/deadbeef", RegWrite, WriteRegister, WriteData); end
    cycle();
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL alu_idle got=%0b exp=0", RegWrite); end
  endtask

  task automatic test_scoreboard();
    idle(); issue_valid = 1; issue_rd = 9; rs_addr = 9; rt_addr = 0;
    cycle(); idle();
    checks++; if (read_stall !== 1'b1) begin failures++; $display("FAIL sb_stall_set got=%0b exp=1", read_stall); end
    mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h1234;
    cycle(); idle();
    cycle();
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd9 || WriteData !== 32'h1234) begin
      failures++; $display("FAIL sb_mdu_write got=%0b/%0d/%0h exp=1/9/1234", RegWrite, WriteRegister, WriteData); end
    checks++; if (read_stall !== 1'b1) begin failures++; $display("FAIL sb_stall_hold got=%0b exp=1", read_stall); end
    cycle();
    checks++; if (read_stall !== 1'b0) begin failures++; $display("FAIL sb_stall_clear got=%0b exp=0", read_stall); end
    rs_addr = 0;
  endtask

  task automatic test_fifo_full();
    for (int i = 1; i <= 5; i++) begin
      idle(); alu_valid = 1; alu_rd = 1; alu_data = 32'(i);
      mdu_valid = 1; mdu_rd = 5'(i); mdu_data = 32'h100 + 32'(i);
      cycle();
      if (i == 3) begin
        checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL full_ready3 got=%0b exp=1", mdu_ready); end
      end
      if (i >= 4) begin
        checks++; if (mdu_ready !== 1'b0) begin failures++; $display("FAIL full_ready%0d got=%0b exp=0", i, mdu_ready); end
      end
    end
    idle();
    for (int i = 1; i <= 4; i++) begin
      cycle();
      checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'(i) || WriteData !== 32'h100 + 32'(i)) begin
        failures++; $display("FAIL full_pop%0d got=%0b/%0d/%0h exp=1/%0d/%0h", i, RegWrite, WriteRegister, WriteData, i, 32'h100 + i); end
    end
    cycle();
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL full_fifth_dropped got=%0b exp=0", RegWrite); end
  endtask

  task automatic test_starvation();
    do_reset();
    idle(); mdu_valid = 1; mdu_rd = 3; mdu_data = 32'hABC;
    cycle(); idle();
    alu_valid = 1; alu_rd = 2;
    for (int i = 1; i <= 8; i++) begin
      alu_data = 32'(i);
      cycle();
      if (i == 7) begin
        checks++; if (alu_hold !== 1'b0) begin failures++; $display("FAIL starve_early got=%0b exp=0", alu_hold); end
      end
    end
    checks++; if (alu_hold !== 1'b1) begin failures++; $display("FAIL starve_hold got=%0b exp=1", alu_hold); end
    idle(); cycle();
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd3 || WriteData !== 32'hABC) begin
      failures++; $display("FAIL starve_pop got=%0b/%0d/%0h exp=1/3/abc", RegWrite, WriteRegister, WriteData); end
    checks++; if (alu_hold !== 1'b0) begin failures++; $display("FAIL starve_release got=%0b exp=0", alu_hold); end
  endtask

  task automatic test_waw_and_rd0();
    do_reset();
    idle(); issue_valid = 1; issue_rd = 7;
    cycle(); idle();
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    cycle(); idle();
    checks++; if (waw_error !== 1'b1) begin failures++; $display("FAIL waw_set got=%0b exp=1", waw_error); end
    repeat (3) cycle();
    checks++; if (waw_error !== 1'b1) begin failures++; $display("FAIL waw_sticky got=%0b exp=1", waw_error); end
    mdu_valid = 1; mdu_rd = 0; mdu_data = 32'h55;
    cycle(); idle();
    cycle();
    checks++; if (RegWrite !== 1'b0 || mdu_ready !== 1'b1) begin
      failures++; $display("FAIL rd0_pop got=%0b/%0b exp=0/1", RegWrite, mdu_ready); end
    mdu_valid = 1; mdu_rd = 4; mdu_data = 32'h44;
    cycle(); idle();
    cycle();
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd4 || WriteData !== 32'h44) begin
      failures++; $display("FAIL rd0_next got=%0b/%0d/%0h exp=1/4/44", RegWrite, WriteRegister, WriteData); end
    reset = 1; cycle(); reset = 0;
    checks++; if (waw_error !== 1'b0) begin failures++; $display("FAIL waw_reset got=%0b exp=0", waw_error); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      alu_valid   = !mHold && ($urandom_range(0, 99) < 55);
      alu_rd      = 5'($urandom_range(0, 31));
      alu_data    = $urandom;
      mdu_valid   = ($urandom_range(0, 99) < 50);
      mdu_rd      = 5'($urandom_range(0, 31));
      mdu_data    = $urandom;
      issue_valid = ($urandom_range(0, 99) < 30);
      issue_rd    = 5'($urandom_range(0, 31));
      rs_addr     = 5'($urandom_range(0, 31));
      rt_addr     = 5'($urandom_range(0, 31));
      cycle();
      checks++; if (RegWrite !== mRegWrite) begin failures++; $display("FAIL rnd_regwrite i=%0d got=%0b exp=%0b", i, RegWrite, mRegWrite); end
      if (mRegWrite) begin
        checks++; if (WriteRegister !== mWrReg || WriteData !== mWrData) begin
          failures++; $display("FAIL rnd_wdata i=%0d got=%0d/%0h exp=%0d/%0h", i, WriteRegister, WriteData, mWrReg, mWrData); end
      end
      checks++; if (mdu_ready !== (mQ.size() < 4)) begin failures++; $display("FAIL rnd_ready i=%0d got=%0b exp=%0b", i, mdu_ready, mQ.size() < 4); end
      checks++; if (alu_hold !== mHold) begin failures++; $display("FAIL rnd_hold i=%0d got=%0b exp=%0b", i, alu_hold, mHold); end
      checks++; if (waw_error !== mWaw) begin failures++; $display("FAIL rnd_waw i=%0d got=%0b exp=%0b", i, waw_error, mWaw); end
      checks++; if (read_stall !== (mBusy[rs_addr] | mBusy[rt_addr])) begin
        failures++; $display("FAIL rnd_stall i=%0d got=%0b exp=%0b", i, read_stall, mBusy[rs_addr] | mBusy[rt_addr]); end
    end
    reset = 0;
  endtask

  initial begin
    reset = 1; idle(); rs_addr = 0; rt_addr = 0;
    test_reset();
    test_alu_write();
    test_scoreboard();
    test_fifo_full();
    test_starvation();
    test_waw_and_rd0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
